rx_frame_ctrl: RTL and testbench
================================

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE_BIT, default 2, log2 of FIFO word width.
REQ-002 SHALL have parameter DATA_WIDTH, default 2**DATA_SIZE_BIT, FIFO word width in bits (4).
REQ-003 SHALL have parameter SFD_PATTERN, default 8'hA7, start-of-frame delimiter, LSB first on air.
REQ-004 SHALL have ports: i_clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have i_rst  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have i_enable  in  1  receive enable; 0 forces HUNT.
REQ-007 SHALL have i_bit  in  1  recovered bit from CDR o_data.
REQ-008 SHALL have i_bit_valid  in  1  one-cycle strobe from CDR o_flag, qualifies i_bit.
REQ-009 SHALL have i_fifo_full  in  1  FIFO full status.
REQ-010 SHALL have o_wr_en  out  1  FIFO write strobe, one cycle per word.
REQ-011 SHALL have o_wr_data  out  DATA_WIDTH  FIFO write word.
REQ-012 SHALL have o_sync  out  1  high from SFD match until frame end or abort.
REQ-013 SHALL have o_frame_len  out  7  PHR length, valid while o_sync or o_frame_done.
REQ-014 SHALL have o_frame_done  out  1  one-cycle pulse on successful frame end.
REQ-015 SHALL have o_err  out  1  one-cycle pulse on abort (overflow or bad length).

Function
REQ-016 SHALL act only on cycles with i_bit_valid=1; all other cycles hold state (except strobe outputs clearing to 0).
REQ-017 SHALL shift bits LSB first into an 8-bit register: sr <= {i_bit, sr[7:1]}.
REQ-018 SHALL implement states HUNT, PHR, PAYLOAD, with a bit counter and a byte counter.
REQ-019 HUNT: on each valid bit, if the updated sr equals SFD_PATTERN, next state PHR, o_sync=1 from the next cycle, bit counter cleared.
REQ-020 PHR: collect 8 bits; bits [6:0] form the length, bit 7 reserved (ignored); on the 8th bit latch o_frame_len.
REQ-021 PHR with length 0: pulse o_err, clear o_sync, return to HUNT.
REQ-022 PHR with length 1..127: enter PAYLOAD, byte counter = length.
REQ-023 PAYLOAD: pack bits LSB first into DATA_WIDTH words; on each completed word, register o_wr_data and assert o_wr_en for exactly one cycle, one cycle after the completing bit.
REQ-024 Each payload byte SHALL yield 8/DATA_WIDTH writes; the total is length*8/DATA_WIDTH writes.
REQ-025 After the last word: pulse o_frame_done in the same cycle as the final o_wr_en, clear o_sync, return to HUNT.
REQ-026 If i_fifo_full=1 in a cycle where a write is due: suppress o_wr_en, pulse o_err, clear o_sync, return to HUNT; the rest of the frame is discarded.
REQ-027 i_enable=0 in any state SHALL return to HUNT next cycle, clear o_sync and counters, with no o_err or o_frame_done.
REQ-028 HUNT SHALL clear sr on entry, so an SFD needs 8 fresh bits after any abort or frame end.
REQ-029 o_frame_done and o_err SHALL never be asserted in the same cycle.

Reset
REQ-030 Asserting i_rst low SHALL immediately force HUNT, with sr, counters, o_wr_data and o_frame_len = 0, and o_wr_en, o_sync, o_frame_done and o_err = 0.
REQ-031 Reset mid-frame SHALL discard the partial word; no write or pulse follows deassertion.
REQ-032 Deassertion SHALL be synchronized externally; the block needs no internal synchronizer.

Structure
REQ-033 SHALL place the state enum, SFD_PATTERN default and PHR width constants in shared package zigbee_rx_pkg.
REQ-034 SHALL use one sub-module, bit_packer (serial-to-DATA_WIDTH word assembler with done strobe).
REQ-035 SHALL be instantiated between cdr and outFIFO in the receive wrapper; o_wr_en drives inWriteEnable and o_wr_data drives inData.

Verification
REQ-036 Feed preamble 32x'0', SFD A7, PHR 0x02, payload 0x3C 0x5A LSB first, FIFO not full -> 4 writes of 0xC, 0x3, 0xA, 0x5; o_frame_len=2; one o_frame_done with the 4th write.
REQ-037 Feed SFD A7, PHR 0x00 -> o_err pulse after the 8th PHR bit, o_sync low, no writes.
REQ-038 Feed a 3-byte frame with i_fifo_full=1 forced before the 3rd word -> 2 writes, o_err pulse, no o_frame_done; a following valid frame is received intact.
REQ-039 Drive i_rst low in the middle of the payload of a 4-byte frame -> all outputs 0 immediately, no further writes; the next frame is decoded normally.
REQ-040 Feed random bits containing no A7 for 1000 strobes, then an A7-framed 1-byte frame; also gap i_bit_valid at 1-in-8 cycles -> no false sync, exactly 2 writes, o_frame_done once.

Source files
------------

// File: rtl/zigbee_rx_pkg.sv
// Shared types and constants for the receive frame controller.
package zigbee_rx_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PHR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } rx_state_e;

  localparam logic [7:0]  SFD_DEFAULT   = 8'hA7;
  localparam int unsigned PHR_WIDTH     = 8;
  localparam int unsigned LEN_WIDTH     = 7;
  localparam int unsigned BIT_CNT_WIDTH = 3;

endpackage

// File: rtl/bit_packer.sv
// Serial-to-word assembler: packs qualified bits LSB first into DATA_WIDTH words.
module bit_packer
  import zigbee_rx_pkg::*;
#(
  parameter int unsigned DATA_SIZE_BIT = 2,
  parameter int unsigned DATA_WIDTH    = 2**DATA_SIZE_BIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  bit_in,
  input  logic                  valid,
  output logic [DATA_WIDTH-1:0] word_c,
  output logic                  done_c
);

  localparam int unsigned           CNT_WIDTH = DATA_SIZE_BIT;
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-2:0] shreg_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  // The incoming bit is the MSB of the word it completes.
  assign word_c = {bit_in, shreg_q};
  assign done_c = valid && !clr && (cnt_q == CNT_LAST);

  // Partial-word storage and bit position within the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (clr) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (valid) begin
      shreg_q <= word_c[DATA_WIDTH-1:1];
      cnt_q   <= cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive framer: SFD hunt, PHR length capture and payload-to-FIFO word writes.
module rx_frame_ctrl
  import zigbee_rx_pkg::*;
#(
  parameter int unsigned DATA_SIZE_BIT = 2,
  parameter int unsigned DATA_WIDTH    = 2**DATA_SIZE_BIT,
  parameter logic [7:0]  SFD_PATTERN   = SFD_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_bit,
  input  logic                  i_bit_valid,
  input  logic                  i_fifo_full,
  output logic                  o_wr_en,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_sync,
  output logic [LEN_WIDTH-1:0]  o_frame_len,
  output logic                  o_frame_done,
  output logic                  o_err
);

  localparam logic [BIT_CNT_WIDTH-1:0] BIT_LAST = BIT_CNT_WIDTH'(PHR_WIDTH - 1);

  rx_state_e                state_q, state_d;
  logic [PHR_WIDTH-1:0]     sr_q, sr_d, sr_shift;
  logic [BIT_CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic [LEN_WIDTH-1:0]     byte_cnt_q, byte_cnt_d;
  logic                     wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                     sync_q, sync_d;
  logic [LEN_WIDTH-1:0]     frame_len_q, frame_len_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     leave;

  logic                     pack_clr;
  logic [DATA_WIDTH-1:0]    pack_word_c;
  logic                     pack_done_c;

  // Packer only runs while collecting payload; anything else flushes it.
  assign pack_clr = (state_q != ST_PAYLOAD) || !i_enable;

  bit_packer #(
    .DATA_SIZE_BIT (DATA_SIZE_BIT),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_packer (
    .clk    (i_clk),
    .rst_n  (i_rst),
    .clr    (pack_clr),
    .bit_in (i_bit),
    .valid  (i_bit_valid),
    .word_c (pack_word_c),
    .done_c (pack_done_c)
  );

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_HUNT;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      sync_q      <= 1'b0;
      frame_len_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      sync_q      <= sync_d;
      frame_len_q <= frame_len_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic; 'leave' funnels every exit path into a clean HUNT entry.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    sync_d      = sync_q;
    frame_len_d = frame_len_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    leave       = 1'b0;
    sr_shift    = {i_bit, sr_q[PHR_WIDTH-1:1]};

    if (!i_enable) begin
      leave = 1'b1;
    end else if (i_bit_valid) begin
      case (state_q)
        ST_HUNT: begin
          sr_d = sr_shift;
          if (sr_shift == SFD_PATTERN) begin
            state_d   = ST_PHR;
            sync_d    = 1'b1;
            bit_cnt_d = '0;
          end
        end
        ST_PHR: begin
          sr_d      = sr_shift;
          bit_cnt_d = bit_cnt_q + BIT_CNT_WIDTH'(1);
          if (bit_cnt_q == BIT_LAST) begin
            frame_len_d = sr_shift[LEN_WIDTH-1:0];
            if (sr_shift[LEN_WIDTH-1:0] == '0) begin
              err_d = 1'b1;
              leave = 1'b1;
            end else begin
              state_d    = ST_PAYLOAD;
              byte_cnt_d = sr_shift[LEN_WIDTH-1:0];
              bit_cnt_d  = '0;
            end
          end
        end
        ST_PAYLOAD: begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_WIDTH'(1);
          if (pack_done_c) begin
            if (i_fifo_full) begin
              err_d = 1'b1;
              leave = 1'b1;
            end else begin
              wr_en_d   = 1'b1;
              wr_data_d = pack_word_c;
              if (bit_cnt_q == BIT_LAST) begin
                byte_cnt_d = byte_cnt_q - LEN_WIDTH'(1);
                if (byte_cnt_q == LEN_WIDTH'(1)) begin
                  done_d = 1'b1;
                  leave  = 1'b1;
                end
              end
            end
          end
        end
        default: begin
          leave = 1'b1;
        end
      endcase
    end

    if (leave) begin
      state_d    = ST_HUNT;
      sr_d       = '0;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      sync_d     = 1'b0;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_data    = wr_data_q;
  assign o_sync       = sync_q;
  assign o_frame_len  = frame_len_q;
  assign o_frame_done = done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: bit-stream reference model plus directed and random frames.
module tb_rx_frame_ctrl;

  localparam int unsigned DSB = 2;
  localparam int unsigned W   = 2**DSB;
  localparam logic [7:0]  SFD = 8'hA7;

  logic         clk = 1'b0;
  logic         rst, en, bit_i, valid, full;
  logic         o_wr_en, o_sync, o_frame_done, o_err;
  logic [W-1:0] o_wr_data;
  logic [6:0]   o_frame_len;

  rx_frame_ctrl #(.DATA_SIZE_BIT(DSB), .DATA_WIDTH(W), .SFD_PATTERN(SFD)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (en),
    .i_bit        (bit_i),
    .i_bit_valid  (valid),
    .i_fifo_full  (full),
    .o_wr_en      (o_wr_en),
    .o_wr_data    (o_wr_data),
    .o_sync       (o_sync),
    .o_frame_len  (o_frame_len),
    .o_frame_done (o_frame_done),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Stimulus knobs
  int   gap_lo = 0, gap_hi = 0, full_pct = 0, drop_pm = 0;
  logic full_force = 1'b0;
  logic [7:0] pl[$];

  // Reference model: bits since HUNT entry, bits since SFD, frame length
  bit         hunt_q[$];
  bit         fq[$];
  bit         in_frame;
  int         m_len_int;
  logic       m_wr_en, m_sync, m_done, m_err;
  logic [W-1:0] m_wr_data;
  logic [6:0] m_len;

  // Observed DUT activity per scenario
  logic [W-1:0] dut_wr_q[$];
  int dut_done_cnt, dut_err_cnt, done_wr_idx, sync_rise;
  logic sync_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: dut=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    hunt_q.delete(); fq.delete();
    in_frame = 1'b0; m_len_int = 0;
    m_wr_en = 1'b0; m_sync = 1'b0; m_done = 1'b0; m_err = 1'b0;
    m_wr_data = '0; m_len = '0;
  endtask

  task automatic leave_frame();
    in_frame = 1'b0; m_sync = 1'b0;
    hunt_q.delete(); fq.delete();
  endtask

  // The last eight bits seen in HUNT (zeros before HUNT entry), oldest = pattern bit 0
  function automatic bit sfd_match();
    int n = hunt_q.size();
    for (int k = 0; k < 8; k++) begin
      int idx = n - 8 + k;
      bit b = (idx >= 0) ? hunt_q[idx] : 1'b0;
      if (b != SFD[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock edge of the model using the inputs that were applied for that edge.
  task automatic model_step();
    int n;
    if (!rst) begin model_reset(); return; end
    m_wr_en = 1'b0; m_done = 1'b0; m_err = 1'b0;
    if (!en) begin
      leave_frame();
    end else if (valid) begin
      if (!in_frame) begin
        hunt_q.push_back(bit_i);
        if (hunt_q.size() > 8) void'(hunt_q.pop_front());
        if (sfd_match()) begin in_frame = 1'b1; fq.delete(); m_sync = 1'b1; end
      end else begin
        fq.push_back(bit_i);
        n = fq.size();
        if (n == 8) begin
          m_len_int = 0;
          for (int k = 0; k < 7; k++) if (fq[k]) m_len_int += (1 << k);
          m_len = 7'(m_len_int);
          if (m_len_int == 0) begin m_err = 1'b1; leave_frame(); end
        end else if (n > 8 && ((n - 8) % W) == 0) begin
          if (full) begin
            m_err = 1'b1; leave_frame();
          end else begin
            m_wr_en = 1'b1;
            for (int k = 0; k < W; k++) m_wr_data[k] = fq[n - W + k];
            if (n - 8 == m_len_int * 8) begin m_done = 1'b1; leave_frame(); end
          end
        end
      end
    end
  endtask

  task automatic tick(input logic e, input logic b, input logic v);
    en = e; bit_i = b; valid = v;
    full = full_force | ((full_pct > 0) && ($urandom_range(99, 0) < full_pct));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1, 1'($urandom), 1'b0);
  endtask

  task automatic send_bit(input logic b);
    if (drop_pm > 0 && $urandom_range(999, 0) < drop_pm) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, b, 1'b1);
    repeat ($urandom_range(gap_hi, gap_lo)) tick(1'b1, 1'($urandom), 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b8);
    for (int k = 0; k < 8; k++) send_bit(b8[k]);
  endtask

  task automatic send_frame(input logic [7:0] phr);
    send_byte(SFD);
    send_byte(phr);
    foreach (pl[i]) send_byte(pl[i]);
  endtask

  task automatic clr_counts();
    dut_wr_q.delete();
    dut_done_cnt = 0; dut_err_cnt = 0; done_wr_idx = 0; sync_rise = 0;
  endtask

  // Per-cycle compare against the model, plus activity recording.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("wr_en", 32'(o_wr_en), 32'(m_wr_en));
        check("sync", 32'(o_sync), 32'(m_sync));
        check("frame_done", 32'(o_frame_done), 32'(m_done));
        check("err", 32'(o_err), 32'(m_err));
        check("done_err_excl", 32'(o_frame_done & o_err), 32'd0);
        if (m_wr_en) check("wr_data", 32'(o_wr_data), 32'(m_wr_data));
        if (m_sync || m_done) check("frame_len", 32'(o_frame_len), 32'(m_len));
      end
      if (o_wr_en) dut_wr_q.push_back(o_wr_data);
      if (o_frame_done) begin dut_done_cnt++; done_wr_idx = dut_wr_q.size(); end
      if (o_err) dut_err_cnt++;
      if (o_sync && !sync_prev) sync_rise++;
      sync_prev = o_sync;
    end
  end

  initial begin
    logic [7:0] win;
    logic       b;
    int         len;
    logic [7:0] phr;

    rst = 1'b1; en = 1'b0; bit_i = 1'b0; valid = 1'b0; full = 1'b0;
    #1 rst = 1'b0;
    model_reset();
    #1;
    check("rst_wr_en", 32'(o_wr_en), 32'd0);
    check("rst_wr_data", 32'(o_wr_data), 32'd0);
    check("rst_sync", 32'(o_sync), 32'd0);
    check("rst_frame_len", 32'(o_frame_len), 32'd0);
    check("rst_done", 32'(o_frame_done), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    rst = 1'b1;
    idle(2);

    // Basic frame: preamble, SFD, length 2, payload 3C 5A
    clr_counts();
    repeat (32) send_bit(1'b0);
    pl.delete(); pl.push_back(8'h3C); pl.push_back(8'h5A);
    send_frame(8'h02);
    idle(4);
    check("basic_writes", 32'(dut_wr_q.size()), 32'd4);
    if (dut_wr_q.size() == 4) begin
      check("basic_w0", 32'(dut_wr_q[0]), 32'hC);
      check("basic_w1", 32'(dut_wr_q[1]), 32'h3);
      check("basic_w2", 32'(dut_wr_q[2]), 32'hA);
      check("basic_w3", 32'(dut_wr_q[3]), 32'h5);
    end
    check("basic_len", 32'(o_frame_len), 32'd2);
    check("basic_done", 32'(dut_done_cnt), 32'd1);
    check("basic_done_at", 32'(done_wr_idx), 32'd4);
    check("basic_err", 32'(dut_err_cnt), 32'd0);

    // Zero-length PHR aborts
    clr_counts();
    pl.delete();
    send_frame(8'h00);
    idle(3);
    check("len0_err", 32'(dut_err_cnt), 32'd1);
    check("len0_writes", 32'(dut_wr_q.size()), 32'd0);
    check("len0_sync", 32'(o_sync), 32'd0);
    check("len0_done", 32'(dut_done_cnt), 32'd0);

    // FIFO full before the third word of a 3-byte frame
    clr_counts();
    gap_lo = 0; gap_hi = 2;
    send_byte(SFD); send_byte(8'h03); send_byte(8'h11);
    full_force = 1'b1;
    send_byte(8'h22); send_byte(8'h33);
    full_force = 1'b0;
    idle(3);
    check("full_writes", 32'(dut_wr_q.size()), 32'd2);
    check("full_err", 32'(dut_err_cnt), 32'd1);
    check("full_done", 32'(dut_done_cnt), 32'd0);
    clr_counts();
    pl.delete(); pl.push_back(8'h96); pl.push_back(8'hE1);
    send_frame(8'h02);
    idle(3);
    check("after_full_writes", 32'(dut_wr_q.size()), 32'd4);
    check("after_full_done", 32'(dut_done_cnt), 32'd1);
    if (dut_wr_q.size() == 4) check("after_full_w3", 32'(dut_wr_q[3]), 32'hE);

    // Reset in the middle of a 4-byte payload
    clr_counts();
    send_byte(SFD); send_byte(8'h04); send_byte(8'h5A); send_byte(8'hF7);
    for (int k = 0; k < 3; k++) send_bit(1'b1);
    rst = 1'b0;
    model_reset();
    #1;
    check("midrst_wr_en", 32'(o_wr_en), 32'd0);
    check("midrst_wr_data", 32'(o_wr_data), 32'd0);
    check("midrst_sync", 32'(o_sync), 32'd0);
    check("midrst_len", 32'(o_frame_len), 32'd0);
    check("midrst_done", 32'(o_frame_done), 32'd0);
    check("midrst_err", 32'(o_err), 32'd0);
    repeat (2) tick(1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    clr_counts();
    idle(6);
    check("postrst_writes", 32'(dut_wr_q.size()), 32'd0);
    check("postrst_pulses", 32'(dut_done_cnt + dut_err_cnt), 32'd0);
    pl.delete(); pl.push_back(8'h12); pl.push_back(8'h34); pl.push_back(8'h56); pl.push_back(8'h78);
    send_frame(8'h04);
    idle(3);
    check("postrst_frame_writes", 32'(dut_wr_q.size()), 32'd8);
    check("postrst_frame_done", 32'(dut_done_cnt), 32'd1);

    // Random frames: random gaps, reserved bit, occasional full and enable drops
    gap_lo = 0; gap_hi = 3; full_pct = 3; drop_pm = 3;
    for (int f = 0; f < 12; f++) begin
      tick(1'b0, 1'b0, 1'b0);
      len = int'($urandom_range(6, 1));
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      phr = {1'($urandom), 7'(len)};
      if (f == 5) phr[6:0] = 7'd0;
      send_frame(phr);
      idle(4);
    end
    full_pct = 0; drop_pm = 0;

    // Long SFD-free noise at one strobe in eight, then a 1-byte frame
    tick(1'b0, 1'b0, 1'b0);
    clr_counts();
    gap_lo = 7; gap_hi = 7;
    win = 8'h00;
    for (int i = 0; i < 1000; i++) begin
      b = 1'($urandom);
      if ({b, win[7:1]} == SFD) b = ~b;
      win = {b, win[7:1]};
      send_bit(b);
    end
    check("noise_sync", 32'(sync_rise), 32'd0);
    repeat (8) send_bit(1'b0);
    pl.delete(); pl.push_back(8'hC3);
    send_frame(8'h01);
    idle(10);
    check("noise_sync_total", 32'(sync_rise), 32'd1);
    check("noise_writes", 32'(dut_wr_q.size()), 32'd2);
    check("noise_done", 32'(dut_done_cnt), 32'd1);
    if (dut_wr_q.size() == 2) begin
      check("noise_w0", 32'(dut_wr_q[0]), 32'h3);
      check("noise_w1", 32'(dut_wr_q[1]), 32'hC);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
